// File: rtl/dmem_print_sequencer.sv
// Data-memory arbiter shared by the MEM stage and a print-string engine.
// While idle, CPU traffic passes through untouched. A print request stalls the
// pipeline, then streams NUL-terminated bytes from memory onto a valid/ready port.
module dmem_print_sequencer #(
  parameter int MAX_LEN = 256
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cpu_mem_write,
  input  logic [31:0] i_cpu_addr,
  input  logic [31:0] i_cpu_write_data,
  output logic [31:0] o_cpu_read_data,
  input  logic        i_print_req,
  input  logic [31:0] i_print_addr,
  output logic        o_stall,
  output logic        o_mem_write,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_write_data,
  input  logic [31:0] i_mem_read_data,
  output logic        o_char_valid,
  output logic [7:0]  o_char_data,
  input  logic        i_char_ready,
  output logic        o_print_done,
  output logic        o_print_trunc,
  output logic [1:0]  o_state
);

  // Character handshake: a byte transfers on any rising clk edge where
  // o_char_valid and i_char_ready are both high; o_char_data is held stable
  // while o_char_valid is high and i_char_ready is low.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EMIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [15:0] LP_MAX_LEN = 16'(MAX_LEN);

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_ptr;
  logic [15:0] r_count;
  logic [31:0] r_word;
  logic        r_trunc;

  logic [7:0]  w_byte;
  logic        w_nul;
  logic        w_accept;
  logic        w_last;
  logic [31:0] w_ptr_inc;

  always_comb begin
    w_byte = 8'h00;
    case (r_ptr[1:0])
      2'd0: w_byte = r_word[7:0];
      2'd1: w_byte = r_word[15:8];
      2'd2: w_byte = r_word[23:16];
      2'd3: w_byte = r_word[31:24];
      default: w_byte = 8'h00;
    endcase
  end

  assign w_nul     = (w_byte == 8'h00);
  assign w_accept  = (r_state == S_EMIT) && !w_nul && i_char_ready;
  assign w_last    = ((r_count + 16'd1) == LP_MAX_LEN);
  assign w_ptr_inc = r_ptr + 32'd1;
  assign o_state   = r_state;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr   <= 32'd0;
      r_count <= 16'd0;
      r_word  <= 32'd0;
      r_trunc <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_print_req) begin
            r_ptr   <= i_print_addr;
            r_count <= 16'd0;
            r_trunc <= 1'b0;
          end
        end
        S_FETCH: r_word <= i_mem_read_data;
        S_EMIT: begin
          if (w_nul) begin
            r_trunc <= 1'b0;
          end else if (w_accept) begin
            r_ptr   <= w_ptr_inc;
            r_count <= r_count + 16'd1;
            r_trunc <= w_last;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next           = r_state;
    o_stall          = 1'b0;
    o_mem_write      = 1'b0;
    o_mem_addr       = 32'd0;
    o_mem_write_data = 32'd0;
    o_cpu_read_data  = 32'd0;
    o_char_valid     = 1'b0;
    o_char_data      = 8'h00;
    o_print_done     = 1'b0;
    o_print_trunc    = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Gated by reset so the memory sees no CPU traffic while reset is held.
        if (!i_rst) begin
          o_mem_write      = i_cpu_mem_write;
          o_mem_addr       = i_cpu_addr;
          o_mem_write_data = i_cpu_write_data;
          o_cpu_read_data  = i_mem_read_data;
        end
        if (i_print_req) w_next = S_FETCH;
      end
      S_FETCH: begin
        o_stall    = 1'b1;
        o_mem_addr = {2'b00, r_ptr[31:2]};
        w_next     = S_EMIT;
      end
      S_EMIT: begin
        o_stall = 1'b1;
        if (w_nul) begin
          w_next = S_DONE;
        end else begin
          o_char_valid = 1'b1;
          o_char_data  = w_byte;
          if (i_char_ready) begin
            // Length limit wins over a word crossing.
            if (w_last)                    w_next = S_DONE;
            else if (w_ptr_inc[1:0] == 2'd0) w_next = S_FETCH;
          end
        end
      end
      S_DONE: begin
        o_stall       = 1'b1;
        o_print_done  = 1'b1;
        o_print_trunc = r_trunc;
        w_next        = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_print_sequencer.sv
// Bench for dmem_print_sequencer: a word memory behind the main instance, a
// constant-'A' memory behind a MAX_LEN=4 instance, and a byte-walk reference model.
module tb_dmem_print_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_we = 1'b0;
  logic [31:0] cpu_addr = 32'd0;
  logic [31:0] cpu_wdata = 32'd0;
  logic        print_req = 1'b0;
  logic [31:0] print_addr = 32'd0;
  logic        char_ready = 1'b0;
  logic        sel = 1'b0;

  logic [31:0] m_rdata, m_maddr, m_mwdata, m_mrd;
  logic        m_stall, m_mwr, m_valid, m_done, m_trunc;
  logic [7:0]  m_data;
  logic [1:0]  m_state;

  logic [31:0] t_rdata, t_maddr, t_mwdata;
  logic        t_stall, t_mwr, t_valid, t_done, t_trunc;
  logic [7:0]  t_data;
  logic [1:0]  t_state;

  logic [31:0] mem [0:63];
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  logic [31:0] fetch_q[$];
  int          n_pass = 0;
  int          n_total = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (m_mwr) mem[m_maddr[5:0]] <= m_mwdata;
  assign m_mrd = mem[m_maddr[5:0]];

  dmem_print_sequencer u_dut (
    .i_clk(clk), .i_rst(rst),
    .i_cpu_mem_write(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_write_data(cpu_wdata),
    .o_cpu_read_data(m_rdata),
    .i_print_req(print_req), .i_print_addr(print_addr),
    .o_stall(m_stall), .o_mem_write(m_mwr), .o_mem_addr(m_maddr),
    .o_mem_write_data(m_mwdata), .i_mem_read_data(m_mrd),
    .o_char_valid(m_valid), .o_char_data(m_data), .i_char_ready(char_ready),
    .o_print_done(m_done), .o_print_trunc(m_trunc), .o_state(m_state)
  );

  dmem_print_sequencer #(.MAX_LEN(4)) u_trunc (
    .i_clk(clk), .i_rst(rst),
    .i_cpu_mem_write(1'b0), .i_cpu_addr(32'd0), .i_cpu_write_data(32'd0),
    .o_cpu_read_data(t_rdata),
    .i_print_req(print_req), .i_print_addr(print_addr),
    .o_stall(t_stall), .o_mem_write(t_mwr), .o_mem_addr(t_maddr),
    .o_mem_write_data(t_mwdata), .i_mem_read_data(32'h41414141),
    .o_char_valid(t_valid), .o_char_data(t_data), .i_char_ready(char_ready),
    .o_print_done(t_done), .o_print_trunc(t_trunc), .o_state(t_state)
  );

  wire        w_stall = sel ? t_stall : m_stall;
  wire [31:0] w_maddr = sel ? t_maddr : m_maddr;
  wire        w_valid = sel ? t_valid : m_valid;
  wire [7:0]  w_data  = sel ? t_data  : m_data;
  wire        w_done  = sel ? t_done  : m_done;
  wire        w_trunc = sel ? t_trunc : m_trunc;
  wire [1:0]  w_state = sel ? t_state : m_state;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
    @(negedge clk);
    cpu_we = 1'b0;
  endtask

  task automatic fill_random();
    logic [31:0] w;
    for (int i = 0; i < 64; i++) begin
      for (int b = 0; b < 4; b++)
        w[b*8 +: 8] = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      cpu_write(32'(i), w);
    end
  endtask

  function automatic logic [7:0] model_byte(input logic s, input logic [31:0] a);
    logic [31:0] w;
    if (s) return 8'h41;
    w = mem[a[7:2]];
    return w[a[1:0]*8 +: 8];
  endfunction

  // Walk bytes from addr: stop at NUL (which is read) or after maxl characters.
  task automatic model(input logic s, input logic [31:0] addr, input int maxl,
                       output logic tr, output int rb);
    logic [7:0] b;
    exp_q.delete();
    tr = 1'b0;
    rb = 0;
    for (int k = 0; k <= maxl; k++) begin
      if (k == maxl) begin tr = 1'b1; rb = k; break; end
      b = model_byte(s, addr + 32'(k));
      if (b == 8'h00) begin rb = k + 1; break; end
      exp_q.push_back(b);
    end
  endtask

  // mode 0: ready always high, 1: toggling 1,0,1..., 2: random
  task automatic run_print(input logic s, input logic [31:0] addr, input int mode, input int req2_at);
    logic        exp_tr, done, tr_seen, pend;
    logic [7:0]  pend_data;
    logic [31:0] nw;
    int          rb, stall_n;
    sel = s;
    model(s, addr, s ? 4 : 256, exp_tr, rb);
    nw = ((addr + 32'(rb) - 32'd1) >> 2) - (addr >> 2) + 32'd1;
    got_q.delete(); fetch_q.delete();
    done = 1'b0; tr_seen = 1'b0; pend = 1'b0; pend_data = 8'h00; stall_n = 0;
    @(negedge clk);
    print_req = 1'b1; print_addr = addr; char_ready = 1'b0;
    #1 check("stall_in_req_cycle", 32'(w_stall), 32'd0);
    @(negedge clk);
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      print_req  = (cyc == req2_at);
      print_addr = $urandom;
      case (mode)
        0:       char_ready = 1'b1;
        1:       char_ready = (cyc % 2 == 0);
        default: char_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (w_stall) stall_n++;
      if (w_state == 2'd1) fetch_q.push_back(w_maddr);
      if (w_valid) begin
        if (pend) check("char_hold", 32'(w_data), 32'(pend_data));
        if (char_ready) begin
          got_q.push_back(w_data);
          pend = 1'b0;
        end else begin
          pend = 1'b1;
          pend_data = w_data;
        end
      end
      if (w_trunc) check("trunc_with_done", 32'(w_done), 32'd1);
      if (w_done) begin done = 1'b1; tr_seen = w_trunc; end
      @(negedge clk);
    end
    print_req = 1'b0;
    char_ready = 1'b1;
    check("done_seen", 32'(done), 32'd1);
    check("trunc", 32'(tr_seen), 32'(exp_tr));
    check("n_chars", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("char[%0d]", i), 32'(got_q[i]), 32'(exp_q[i]));
    check("n_fetch", 32'(fetch_q.size()), nw);
    for (int i = 0; i < fetch_q.size() && i < int'(nw); i++)
      check($sformatf("fetch[%0d]", i), fetch_q[i], (addr >> 2) + 32'(i));
    if (mode == 0) check("stall_cycles", 32'(stall_n), nw + 32'(rb) + 32'd1);
    #1;
    check("stall_after_done", 32'(w_stall), 32'd0);
    check("no_second_done", 32'(w_done), 32'd0);
    for (int k = 0; k < 1000 && (m_stall || t_stall); k++) @(negedge clk);
    check("quiesce", 32'(m_stall | t_stall), 32'd0);
  endtask

  initial begin
    // Reset: every output low, CPU traffic blocked from the memory.
    cpu_we = 1'b1; cpu_addr = 32'h55; cpu_wdata = 32'hFFFF_FFFF;
    #2;
    check("rst_mem_write", 32'(m_mwr), 32'd0);
    check("rst_mem_addr", m_maddr, 32'd0);
    check("rst_mem_wdata", m_mwdata, 32'd0);
    check("rst_cpu_rdata", m_rdata, 32'd0);
    check("rst_stall", 32'(m_stall), 32'd0);
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_done", 32'({m_done, m_trunc}), 32'd0);
    check("rst_state", 32'(m_state), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0; cpu_we = 1'b0;
    fill_random();

    // T1 pass-through
    cpu_write(32'h10, 32'hDEADBEEF);
    @(negedge clk);
    cpu_addr = 32'h10;
    #1;
    check("t1_read", m_rdata, 32'hDEADBEEF);
    check("t1_mem_addr", m_maddr, 32'h10);
    check("t1_stall", 32'(m_stall), 32'd0);

    // T2 aligned string, T3 unaligned with backpressure
    cpu_write(32'h4, 32'h6C6C6548);
    cpu_write(32'h5, 32'h0000006F);
    run_print(1'b0, 32'h10, 0, -1);
    run_print(1'b0, 32'h12, 1, -1);

    // T4 truncation at MAX_LEN=4, aligned and straddling a word
    run_print(1'b1, 32'h0, 0, -1);
    run_print(1'b1, 32'h7, 0, -1);
    run_print(1'b1, 32'h2, 2, -1);

    // T5 empty string with a second request mid-flight
    cpu_write(32'h0, 32'h0);
    run_print(1'b0, 32'h0, 0, 1);

    // T6 asynchronous reset while a character is pending
    sel = 1'b0;
    @(negedge clk);
    print_req = 1'b1; print_addr = 32'h10; char_ready = 1'b0;
    @(negedge clk);
    print_req = 1'b0;
    for (int k = 0; k < 10 && !m_valid; k++) @(negedge clk);
    check("t6_valid_seen", 32'(m_valid), 32'd1);
    cpu_we = 1'b1; cpu_addr = 32'h30; cpu_wdata = 32'h1234;
    #2 rst = 1'b1;
    #1;
    check("t6_valid", 32'(m_valid), 32'd0);
    check("t6_stall", 32'(m_stall), 32'd0);
    check("t6_mem", 32'({m_mwr, m_maddr != 0, m_mwdata != 0}), 32'd0);
    check("t6_done", 32'(m_done), 32'd0);
    @(negedge clk);
    rst = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0;
    for (int k = 0; k < 4; k++) begin
      #1 check("t6_no_done", 32'({m_done, m_stall}), 32'd0);
      @(negedge clk);
    end
    run_print(1'b0, 32'h10, 0, -1);

    // Random images, start addresses and backpressure
    for (int it = 0; it < 6; it++) begin
      fill_random();
      run_print(1'b0, 32'($urandom_range(0, 200)), 2, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
